// File: rtl/multiply_by_constant_pipelined_avalon_st.sv
// Avalon-ST stage that scales payload beats by a constant and forwards SOP/EOP beats unchanged.
// Sticky flags record product overflow and packet framing violations.
module multiply_by_constant_pipelined_avalon_st #(
  parameter int unsigned IN_WIDTH   = 8,
  parameter int unsigned OUT_WIDTH  = 11,
  parameter int unsigned MULTIPLIER = 2,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned SATURATE   = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  output logic                 in_ready,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_startofpacket,
  input  logic                 in_endofpacket,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_startofpacket,
  output logic                 out_endofpacket,
  output logic                 overflow,
  output logic                 framing_error,
  input  logic                 clear_flags
);

  localparam int unsigned ProdWidth = IN_WIDTH + 32;
  localparam int unsigned PtrWidth  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntWidth  = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {StIdle, StInPacket} frame_state_e;

  frame_state_e state_q, state_d;

  logic [OUT_WIDTH-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]     sop_mem;
  logic [DEPTH-1:0]     eop_mem;

  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic                in_ready_q, in_ready_d;
  logic                overflow_q, overflow_d;
  logic                framing_error_q, framing_error_d;

  logic                 push;
  logic                 pop;
  logic                 is_payload;
  logic [ProdWidth-1:0] product;
  logic                 product_ovf;
  logic [OUT_WIDTH-1:0] beat_data;
  logic                 frame_err_evt;

  assign push       = in_valid & in_ready_q;
  assign pop        = out_valid & out_ready;
  assign is_payload = ~in_startofpacket & ~in_endofpacket;

  // Full-width product so overflow detection never loses carry bits.
  assign product     = ProdWidth'(in_data) * ProdWidth'(MULTIPLIER);
  assign product_ovf = (product >> OUT_WIDTH) != '0;

  always_comb begin
    beat_data = product[OUT_WIDTH-1:0];
    if (!is_payload) begin
      beat_data = OUT_WIDTH'(in_data);
    end else if (product_ovf && (SATURATE != 0)) begin
      beat_data = '1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrWidth'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrWidth'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    count_d    = count_q + CntWidth'(push) - CntWidth'(pop);
    // Registered ready keeps out_ready and in_valid off the in_ready path.
    in_ready_d = (count_d < CntWidth'(DEPTH));
  end

  always_comb begin
    state_d       = state_q;
    frame_err_evt = 1'b0;
    if (push) begin
      unique case (state_q)
        StIdle: begin
          if (!in_startofpacket) begin
            frame_err_evt = 1'b1;
          end else if (!in_endofpacket) begin
            state_d = StInPacket;
          end
        end
        StInPacket: begin
          if (in_startofpacket) begin
            frame_err_evt = 1'b1;
          end else if (in_endofpacket) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // A set event in the same cycle as clear_flags wins.
  always_comb begin
    overflow_d      = (push & is_payload & product_ovf) | (overflow_q & ~clear_flags);
    framing_error_d = frame_err_evt | (framing_error_q & ~clear_flags);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      in_ready_q      <= 1'b0;
      overflow_q      <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      in_ready_q      <= in_ready_d;
      overflow_q      <= overflow_d;
      framing_error_q <= framing_error_d;
    end
  end

  // Storage is reset so the source side reads zero during and right after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
      end
      sop_mem <= '0;
      eop_mem <= '0;
    end else if (push) begin
      data_mem[wr_ptr_q] <= beat_data;
      sop_mem[wr_ptr_q]  <= in_startofpacket;
      eop_mem[wr_ptr_q]  <= in_endofpacket;
    end
  end

  assign in_ready          = in_ready_q;
  assign out_valid         = (count_q != '0);
  assign out_data          = data_mem[rd_ptr_q];
  assign out_startofpacket = sop_mem[rd_ptr_q];
  assign out_endofpacket   = eop_mem[rd_ptr_q];
  assign overflow          = overflow_q;
  assign framing_error     = framing_error_q;

endmodule

// File: doc/multiply_by_constant_pipelined_avalon_st.md
MULTIPLY_BY_CONSTANT_PIPELINED_AVALON_ST -- requirements
Module: multiply_by_constant_pipelined_avalon_st

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 8, input data width in bits.
REQ-002 SHALL have parameter OUT_WIDTH, default 11, output data width in bits (>= IN_WIDTH).
REQ-003 SHALL have parameter MULTIPLIER, default 2, unsigned constant applied to payload beats.
REQ-004 SHALL have parameter DEPTH, default 2, output buffer entries (>= 2).
REQ-005 SHALL have parameter SATURATE, default 1; 1 = clamp on overflow, 0 = truncate to low OUT_WIDTH bits.
REQ-006 SHALL have port clock  in  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-008 SHALL have ports in_ready out 1, in_valid in 1, in_data in IN_WIDTH, in_startofpacket in 1, in_endofpacket in 1: Avalon-ST sink.
REQ-009 SHALL have ports out_ready in 1, out_valid out 1, out_data out OUT_WIDTH, out_startofpacket out 1, out_endofpacket out 1: Avalon-ST source.
REQ-010 SHALL have port overflow  out  1  sticky flag: a payload product exceeded OUT_WIDTH.
REQ-011 SHALL have port framing_error  out  1  sticky flag: packet framing violation.
REQ-012 SHALL have port clear_flags  in  1  synchronous clear of both sticky flags.

Function
REQ-013 SHALL accept a beat on any cycle with in_valid and in_ready both high; in_ready SHALL be high iff buffer occupancy < DEPTH, with no combinational path from out_ready or in_valid.
REQ-014 SHALL present an accepted beat on the source the next cycle when the buffer was empty (latency 1); beats SHALL emerge in acceptance order.
REQ-015 SHALL sustain one beat per cycle while out_ready is held high.
REQ-016 SHALL drop a beat from the buffer on any cycle with out_valid and out_ready both high; out_valid SHALL be high iff occupancy > 0.
REQ-017 SHALL allow simultaneous push and pop in one cycle, leaving occupancy unchanged.
REQ-018 SHALL hold out_data, out_startofpacket, out_endofpacket stable while out_valid high and out_ready low.
REQ-019 Payload beat (neither SOP nor EOP): out_data SHALL be in_data * MULTIPLIER, computed at full width, then clamped to all ones (SATURATE=1) or truncated (SATURATE=0).
REQ-020 Beat with SOP and/or EOP SHALL pass in_data zero-extended to OUT_WIDTH, unmultiplied, with both flags copied unchanged (SOP+EOP on one beat is legal).
REQ-021 overflow SHALL set the cycle after accepting a payload beat whose full-width product >= 2^OUT_WIDTH, in either SATURATE mode.
REQ-022 SHALL track framing with states IDLE and IN_PACKET: IDLE + SOP (no EOP) -> IN_PACKET; IN_PACKET + EOP -> IDLE; SOP+EOP beat leaves state unchanged.
REQ-023 framing_error SHALL set on accepting SOP while IN_PACKET, or a non-SOP beat while IDLE; the beat SHALL still be forwarded, and a SOP while IN_PACKET SHALL keep IN_PACKET.
REQ-024 clear_flags SHALL clear the flags next cycle; a set event in the same cycle SHALL win.
REQ-025 Occupancy SHALL never exceed DEPTH nor underflow; pointers SHALL wrap modulo DEPTH.

Reset
REQ-026 On reset_n low, immediately and asynchronously: occupancy 0, out_valid 0, out_data 0, out_startofpacket 0, out_endofpacket 0, overflow 0, framing_error 0, state IDLE.
REQ-027 in_ready SHALL be 0 while reset_n is low and 1 the first cycle after release; beats in flight at reset SHALL be discarded.

Verification
REQ-028 Defaults, out_ready=1, beats SOP 0x05, 0x03, 0x7F, EOP 0x09 back to back -> 0x005, 0x006, 0x0FE, 0x009 on consecutive cycles, SOP/EOP aligned, no flags.
REQ-029 SATURATE=1, OUT_WIDTH=8, MULTIPLIER=3, payload 0x60 -> out_data 0xFF, overflow=1; SATURATE=0 same stimulus -> 0x20, overflow=1.
REQ-030 out_ready=0, four beats offered -> two accepted, in_ready low; then out_ready=1 -> both emerge in order, remaining two follow with no loss.
REQ-031 SOP, SOP, EOP -> framing_error=1 after second SOP, all three beats forwarded; clear_flags pulse -> framing_error=0.
REQ-032 Single SOP+EOP beat 0xAA -> out_data 0x0AA with both flags, no framing_error.
REQ-033 reset_n low while buffer holds 2 beats -> out_valid=0 immediately, no stale beat after release.
